// File: rtl/npc_lsu_if.sv
// Data-side bus bundle for the NPC load/store unit:
// EX request, memory request/response and WB result.
interface npc_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_wr;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  modport slave (
    input  in_valid, in_wr, in_funct3, in_addr, in_wdata,
    input  mem_rdata, out_ready,
    output in_ready, mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_wstrb, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_wr, in_funct3, in_addr, in_wdata,
    output mem_rdata, out_ready,
    input  in_ready, mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_wstrb, out_valid, out_data, out_err
  );
endinterface

// File: rtl/npc_lsu.sv
// NPC load/store unit: one op at a time, word-aligned
// memory requests with lane shifting and load extension.
module npc_lsu #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  npc_lsu_if.slave   bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t      st;
  logic [CW-1:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        legal;
  logic        aligned;
  logic        ok;
  logic [1:0]  off;
  logic [3:0]  strb;
  logic [31:0] lane;
  logic [31:0] ext;

  assign off = bus.in_addr[1:0];
  assign ok  = legal && aligned;

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      !bus.in_funct3[2] && (bus.in_funct3[1:0] != 2'b11):
        legal = 1'b1;
      bus.in_funct3[2] && !bus.in_funct3[1]:
        legal = !bus.in_wr;
      default:
        legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    unique case (1'b1)
      bus.in_funct3[1:0] == 2'b01: aligned = !bus.in_addr[0];
      bus.in_funct3[1:0] == 2'b10: aligned = (off == 2'b00);
      default:                     aligned = 1'b1;
    endcase
  end

  always_comb begin
    strb = 4'b0000;
    unique case (1'b1)
      bus.in_funct3[1:0] == 2'b00: strb = 4'b0001 << off;
      bus.in_funct3[1:0] == 2'b01: strb = 4'b0011 << off;
      default:                     strb = 4'b1111;
    endcase
  end

  assign lane = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = lane;
    unique case (1'b1)
      f3_q == 3'b000: ext = {{24{lane[7]}}, lane[7:0]};
      f3_q == 3'b001: ext = {{16{lane[15]}}, lane[15:0]};
      f3_q == 3'b100: ext = {24'd0, lane[7:0]};
      f3_q == 3'b101: ext = {16'd0, lane[15:0]};
      default:        ext = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      cnt           <= '0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      bus.in_ready  <= 1'b1;
      bus.mem_en    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.mem_wstrb <= 4'd0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 32'd0;
      bus.out_err   <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.in_valid) begin
            f3_q         <= bus.in_funct3;
            off_q        <= off;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            if (ok) begin
              st            <= REQ;
              bus.mem_en    <= 1'b1;
              bus.mem_wr    <= bus.in_wr;
              bus.mem_addr  <= {bus.in_addr[31:2], 2'b00};
              bus.mem_wdata <= bus.in_wr ?
                               bus.in_wdata << {off, 3'b000} :
                               32'd0;
              bus.mem_wstrb <= bus.in_wr ? strb : 4'd0;
            end else begin
              st            <= RESP;
              bus.out_valid <= 1'b1;
              bus.out_data  <= 32'd0;
              bus.out_err   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (cnt == CW'(MEM_LAT - 1)) begin
            st            <= RESP;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.mem_wstrb <= 4'd0;
            bus.out_valid <= 1'b1;
            bus.out_err   <= 1'b0;
            // stores report zero; the response word is only meaningful for loads
            bus.out_data  <= bus.mem_wr ? 32'd0 : ext;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            st            <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 32'd0;
            bus.out_err   <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/npc_lsu.md
Name: npc_lsu

Overview:
- Load/store unit on the NPC core side of the data-memory port; initiator for the DPI-backed data memory (en/wr/addr/wdata/wstrb -> rdata).
- Accepts one memory operation from EX via valid/ready and drives word-aligned memory requests with byte-lane shifted store data and strobes.
- Extracts, sign/zero-extends load data and returns the result to WB via valid/ready.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- MEM_LAT, 1, cycles mem_en is held per access (>=1); rdata sampled in the last cycle.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  EX presents an operation.
- in_ready  out  1  LSU can accept (IDLE only).
- in_wr  in  1  0 = load, 1 = store.
- in_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only).
- in_addr  in  32  byte address.
- in_wdata  in  32  store data, LSB-aligned.
- mem_en  out  1  memory access enable.
- mem_wr  out  1  0 read, 1 write.
- mem_addr  out  32  word-aligned address {in_addr[31:2],2'b00}.
- mem_wdata  out  32  store data shifted to byte lane.
- mem_wstrb  out  4  byte write strobes.
- mem_rdata  in  32  read word from memory.
- out_valid  out  1  result available to WB.
- out_ready  in  1  WB accepts result.
- out_data  out  32  extended load value; 0 for stores and faults.
- out_err  out  1  misaligned or illegal funct3.

Behaviour:
- Reset: state IDLE; in_ready=1; mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0; out_valid=0, out_data=0, out_err=0; latency counter 0.
- States: IDLE, REQ, RESP.
- IDLE: in_ready=1. On in_valid && in_ready, latch wr, funct3, addr, wdata. If legal and aligned -> REQ; else -> RESP with out_err=1, out_data=0, no mem_en pulse.
- Legality: load funct3 in {000,001,010,100,101}; store funct3 in {000,001,010}. Alignment: H needs addr[0]=0; W needs addr[1:0]=00; B always aligned.
- REQ: mem_en=1 for exactly MEM_LAT cycles; mem_wr, mem_addr, mem_wdata, mem_wstrb stable throughout. On last REQ cycle capture mem_rdata, -> RESP. mem_en=0 in all other states.
- Store lanes: off=addr[1:0]; mem_wdata = wdata << (8*off); wstrb SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111. Loads: mem_wstrb=0, mem_wdata=0.
- Load extraction: byte = rdata >> (8*off) [7:0], half = rdata >> (8*off) [15:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
- RESP: out_valid=1; out_data/out_err held stable until out_valid && out_ready; then -> IDLE, out_valid=0 next cycle. No new accept in the same cycle as response handoff (in_ready=0 in RESP).
- Total accept-to-out_valid latency: MEM_LAT+1 cycles for legal ops; 1 cycle for faults.
- Back-pressure: out_ready low holds RESP indefinitely; no further memory access.
- Reset mid-operation (REQ or RESP): after the edge all outputs at reset values, state IDLE; in-flight operation dropped, no partial store retried.

Test Plan:
- Reset, then SW addr 0x8000_0004 data 0xDEAD_BEEF -> one mem_en cycle (MEM_LAT=1), mem_wr=1, mem_addr 0x8000_0004, wstrb 1111, wdata 0xDEAD_BEEF; out_valid next cycle, out_data 0, out_err 0.
- SB addr 0x8000_0003 data 0x0000_00A5 -> mem_addr 0x8000_0000, wstrb 1000, mem_wdata 0xA500_0000.
- LB addr 0x8000_0002, mem_rdata 0x1280_3456 -> out_data 0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr 0x8000_0002 -> 0x0000_1280.
- LW addr 0x8000_0006 -> no mem_en, out_valid after 1 cycle, out_err=1, out_data=0; funct3 011 load -> same fault.
- MEM_LAT=3, LH addr 0x10 with out_ready=0 for 5 cycles -> mem_en high exactly 3 cycles, out_valid held and out_data stable until out_ready, in_ready=0 throughout.
- Assert rst during REQ of an SW -> mem_en=0, out_valid=0, in_ready=1 after the edge; next LW proceeds normally.
